// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection phase scheduler: state codes, lamp codes
// and small constant helpers used to size the phase counter.
package traffic_pkg;

  localparam logic [2:0] ST_HG  = 3'd0;
  localparam logic [2:0] ST_HY  = 3'd1;
  localparam logic [2:0] ST_AR1 = 3'd2;
  localparam logic [2:0] ST_FG  = 3'd3;
  localparam logic [2:0] ST_FY  = 3'd4;
  localparam logic [2:0] ST_AR2 = 3'd5;
  localparam logic [2:0] ST_PW  = 3'd6;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  typedef enum logic [2:0] {
    HG  = ST_HG,
    HY  = ST_HY,
    AR1 = ST_AR1,
    FG  = ST_FG,
    FY  = ST_FY,
    AR2 = ST_AR2,
    PW  = ST_PW
  } phase_e;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // A one-bit counter is still needed when every duration is a single tick.
  function automatic int cnt_width(input int tmax);
    return (tmax < 2) ? 1 : $clog2(tmax);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: tick pulses for one cycle every TICK_DIV clocks and is
// never realigned by the phase sequencer.
module tick_gen #(
  parameter int TICK_DIV = 125_000_000
) (
  input  logic clk_125M,
  input  logic rst,
  output logic tick
);

  localparam int PW = $clog2(TICK_DIV);

  logic [PW-1:0] presc;

  assign tick = (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk_125M or negedge rst) begin
    if (!rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

endmodule

// File: rtl/phase_scheduler.sv
// Highway / farm-road / pedestrian phase sequencer with emergency preempt.
// Lamps decode from the state register only, so they cannot glitch.
module phase_scheduler
  import traffic_pkg::*;
#(
  parameter int TICK_DIV    = 125_000_000,
  parameter int T_GREEN_MIN = 25,
  parameter int T_YELLOW    = 4,
  parameter int T_ALLRED    = 1,
  parameter int T_WALK      = 10,
  parameter int T_FARM_MAX  = 25
) (
  input  logic       clk_125M,
  input  logic       rst,
  input  logic       c,
  input  logic       ped_req,
  input  logic       emg,
  output logic [2:0] HL,
  output logic [2:0] FL,
  output logic       walk,
  output logic       ped_ack
);

  localparam int T_MAX = imax(imax(imax(T_GREEN_MIN, T_YELLOW), imax(T_ALLRED, T_WALK)),
                              T_FARM_MAX);
  localparam int CW    = cnt_width(T_MAX);

  localparam logic [CW-1:0] GMIN_LAST = CW'(T_GREEN_MIN - 1);
  localparam logic [CW-1:0] YEL_LAST  = CW'(T_YELLOW - 1);
  localparam logic [CW-1:0] AR_LAST   = CW'(T_ALLRED - 1);
  localparam logic [CW-1:0] WALK_LAST = CW'(T_WALK - 1);
  localparam logic [CW-1:0] FMAX_LAST = CW'(T_FARM_MAX - 1);
  localparam logic [CW-1:0] CNT_SAT   = '1;

  phase_e        state;
  phase_e        state_nx;
  logic [CW-1:0] cnt;
  logic          ped_pend;
  logic          tick;
  logic          enter_pw;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk_125M(clk_125M),
    .rst     (rst),
    .tick    (tick)
  );

  assign enter_pw = (state_nx == PW) && (state != PW);

  always_ff @(posedge clk_125M or negedge rst) begin
    if (!rst) begin
      state <= HG;
    end else begin
      state <= state_nx;
    end
  end

  // emg acts off-tick only where it must cut a phase short (FG, PW); elsewhere it
  // steers the AR1 exit or pins HG.
  always_comb begin
    state_nx = state;
    case (state)
      HG: begin
        if (tick && (cnt >= GMIN_LAST) && (c || ped_pend) && !emg) state_nx = HY;
      end
      HY: begin
        if (tick && (cnt == YEL_LAST)) state_nx = AR1;
      end
      AR1: begin
        if (tick && (cnt == AR_LAST)) begin
          if (emg)           state_nx = HG;
          else if (ped_pend) state_nx = PW;
          else if (c)        state_nx = FG;
          else               state_nx = HG;
        end
      end
      FG: begin
        if (emg || (tick && (!c || (cnt == FMAX_LAST)))) state_nx = FY;
      end
      FY: begin
        if (tick && (cnt == YEL_LAST)) state_nx = AR2;
      end
      PW: begin
        if (emg || (tick && (cnt == WALK_LAST))) state_nx = AR2;
      end
      AR2: begin
        if (tick && (cnt == AR_LAST)) state_nx = HG;
      end
      default: state_nx = HG;
    endcase
  end

  // Clearing on PW entry takes precedence over a button press in the same cycle.
  always_ff @(posedge clk_125M or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      ped_pend <= 1'b0;
      ped_ack  <= 1'b0;
    end else begin
      if (state_nx != state) begin
        cnt <= '0;
      end else if (tick && (cnt != CNT_SAT)) begin
        cnt <= cnt + CW'(1);
      end
      ped_ack <= enter_pw;
      if (enter_pw) begin
        ped_pend <= 1'b0;
      end else if (ped_req) begin
        ped_pend <= 1'b1;
      end
    end
  end

  always_comb begin
    HL   = LT_RED;
    FL   = LT_RED;
    walk = 1'b0;
    case (state)
      HG: HL = LT_GRN;
      HY: HL = LT_YEL;
      FG: FL = LT_GRN;
      FY: FL = LT_YEL;
      PW: walk = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_phase_scheduler.sv
// Scoreboard bench: expected lamp segments (lamps + duration in cycles) are queued
// with each scenario's stimulus and compared whenever the DUT lamps change.
module tb_phase_scheduler;

  logic       clk_125M;
  logic       rst;
  logic       c;
  logic       ped_req;
  logic       emg;
  logic [2:0] HL;
  logic [2:0] FL;
  logic       walk;
  logic       ped_ack;

  phase_scheduler #(
    .TICK_DIV   (4),
    .T_GREEN_MIN(3),
    .T_YELLOW   (2),
    .T_ALLRED   (1),
    .T_WALK     (2),
    .T_FARM_MAX (5)
  ) dut (
    .clk_125M(clk_125M),
    .rst     (rst),
    .c       (c),
    .ped_req (ped_req),
    .emg     (emg),
    .HL      (HL),
    .FL      (FL),
    .walk    (walk),
    .ped_ack (ped_ack)
  );

  localparam logic [6:0] L_HG = {3'b001, 3'b100, 1'b0};
  localparam logic [6:0] L_HY = {3'b010, 3'b100, 1'b0};
  localparam logic [6:0] L_AR = {3'b100, 3'b100, 1'b0};
  localparam logic [6:0] L_FG = {3'b100, 3'b001, 1'b0};
  localparam logic [6:0] L_FY = {3'b100, 3'b010, 1'b0};
  localparam logic [6:0] L_PW = {3'b100, 3'b100, 1'b1};

  typedef struct {
    logic [6:0] lights;
    int         len;
    string      tag;
  } seg_t;

  seg_t       exp_q[$];
  logic [6:0] cur_lights;
  int         cur_len;
  int         cyc;
  int         n_checks;
  int         n_errors;

  initial begin
    clk_125M = 1'b0;
    forever #4 clk_125M = ~clk_125M;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input string tag, input logic [6:0] l, input int n);
    seg_t e;
    e.lights = l;
    e.len    = n;
    e.tag    = tag;
    exp_q.push_back(e);
  endtask

  task automatic sample();
    logic [6:0] l;
    logic       new_seg;
    seg_t       e;
    l       = {HL, FL, walk};
    new_seg = 1'b0;
    if (l != cur_lights) begin
      chk("seg_avail", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.tag, "_lights"}, 32'(cur_lights), 32'(e.lights));
        chk({e.tag, "_len"}, cur_len, e.len);
      end
      cur_lights = l;
      cur_len    = 1;
      new_seg    = 1'b1;
    end else begin
      cur_len++;
    end
    if (ped_ack || (new_seg && walk)) chk("ped_ack", 32'(ped_ack), 32'(new_seg && walk));
  endtask

  task automatic run_to(input int n);
    while (cyc < n) begin
      @(negedge clk_125M);
      cyc++;
      sample();
    end
  endtask

  task automatic do_reset();
    @(negedge clk_125M);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_HL", 32'(HL), 32'(3'b001));
    chk("rst_FL", 32'(FL), 32'(3'b100));
    chk("rst_walk", 32'(walk), 32'd0);
    chk("rst_ped_ack", 32'(ped_ack), 32'd0);
    exp_q.delete();
    @(negedge clk_125M);
    rst        = 1'b1;
    cyc        = 0;
    cur_lights = {HL, FL, walk};
    cur_len    = 1;
  endtask

  task automatic end_scn(input string tag);
    chk({tag, "_q_left"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    rst      = 1'b0;
    c        = 1'b0;
    ped_req  = 1'b0;
    emg      = 1'b0;

    // c held: full cycle through the farm road at maximum green
    c = 1'b1;
    do_reset();
    push("s1_hg", L_HG, 12); push("s1_hy", L_HY, 8); push("s1_ar1", L_AR, 4);
    push("s1_fg", L_FG, 20); push("s1_fy", L_FY, 8); push("s1_ar2", L_AR, 4);
    push("s1_hg2", L_HG, 12);
    run_to(70);
    end_scn("s1");

    // reset asserted mid-FY, then HG holds with no requests
    c = 1'b1;
    do_reset();
    push("s0_hg", L_HG, 12); push("s0_hy", L_HY, 8); push("s0_ar1", L_AR, 4);
    push("s0_fg", L_FG, 20);
    run_to(48);
    end_scn("s0");
    c = 1'b0;
    do_reset();
    run_to(100);
    chk("s0_hold_lights", 32'(cur_lights), 32'(L_HG));
    chk("s0_hold_len", cur_len, 101);
    end_scn("s0b");

    // car leaves two ticks into FG
    c = 1'b1;
    do_reset();
    push("s2_hg", L_HG, 12); push("s2_hy", L_HY, 8); push("s2_ar1", L_AR, 4);
    push("s2_fg", L_FG, 12); push("s2_fy", L_FY, 8); push("s2_ar2", L_AR, 4);
    run_to(32);
    c = 1'b0;
    run_to(80);
    end_scn("s2");

    // pedestrian only, plus a press during the walk served later
    c = 1'b0;
    do_reset();
    push("s3_hg", L_HG, 12); push("s3_hy", L_HY, 8); push("s3_ar1", L_AR, 4);
    push("s3_pw", L_PW, 8); push("s3_ar2", L_AR, 4); push("s3_hg2", L_HG, 12);
    push("s3_hy2", L_HY, 8); push("s3_ar1b", L_AR, 4); push("s3_pw2", L_PW, 8);
    push("s3_ar2b", L_AR, 4);
    run_to(4);  ped_req = 1'b1;
    run_to(5);  ped_req = 1'b0;
    run_to(26); ped_req = 1'b1;
    run_to(27); ped_req = 1'b0;
    run_to(100);
    end_scn("s3");

    // emergency during FG, held long in HG, then released
    c = 1'b1;
    do_reset();
    push("s4_hg", L_HG, 12); push("s4_hy", L_HY, 8); push("s4_ar1", L_AR, 4);
    push("s4_fg", L_FG, 3); push("s4_fy", L_FY, 5); push("s4_ar2", L_AR, 4);
    push("s4_hg_emg", L_HG, 224); push("s4_hy2", L_HY, 8); push("s4_ar1b", L_AR, 4);
    run_to(26);
    emg = 1'b1;
    run_to(256);
    chk("s4_emg_hold_lights", 32'(cur_lights), 32'(L_HG));
    chk("s4_emg_hold_len", cur_len, 221);
    emg = 1'b0;
    run_to(280);
    end_scn("s4");

    // button at the AR1 exit tick while preempted: HG wins, request survives
    c = 1'b1;
    do_reset();
    push("s5_hg", L_HG, 12); push("s5_hy", L_HY, 8); push("s5_ar1", L_AR, 4);
    push("s5_hg_emg", L_HG, 20); push("s5_hy2", L_HY, 8); push("s5_ar1b", L_AR, 4);
    push("s5_pw", L_PW, 8); push("s5_ar2", L_AR, 4);
    run_to(23);
    emg = 1'b1; ped_req = 1'b1; c = 1'b0;
    run_to(24);
    ped_req = 1'b0;
    run_to(40);
    emg = 1'b0;
    run_to(90);
    end_scn("s5");

    // pedestrian beats car; press at PW entry is dropped; fresh min green before FG
    c = 1'b1;
    do_reset();
    push("s6_hg", L_HG, 12); push("s6_hy", L_HY, 8); push("s6_ar1", L_AR, 4);
    push("s6_pw", L_PW, 8); push("s6_ar2", L_AR, 4); push("s6_hg2", L_HG, 12);
    push("s6_hy2", L_HY, 8); push("s6_ar1b", L_AR, 4); push("s6_fg", L_FG, 20);
    push("s6_fy", L_FY, 8); push("s6_ar2b", L_AR, 4);
    run_to(4);  ped_req = 1'b1;
    run_to(5);  ped_req = 1'b0;
    run_to(23); ped_req = 1'b1;
    run_to(24); ped_req = 1'b0;
    run_to(95);
    end_scn("s6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
